// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 definitions: prefix bytes, modifier codes, decoder
// states and the layout of a queued key event.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_BAT    = 8'hAA;
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;

   localparam logic [7:0] PS2_LSHIFT = 8'h12;
   localparam logic [7:0] PS2_RSHIFT = 8'h59;
   localparam logic [7:0] PS2_CAPS   = 8'h58;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } ps2_state_e;

   // Event word: {ext, release, code[7:0], ascii[7:0]}
   localparam int EV_W         = 18;
   localparam int EV_ASCII_LSB = 0;
   localparam int EV_CODE_LSB  = 8;
   localparam int EV_REL_BIT   = 16;
   localparam int EV_EXT_BIT   = 17;

   function automatic logic [EV_W-1:0] pack_event(input logic       ext,
                                                  input logic       rel,
                                                  input logic [7:0] code,
                                                  input logic [7:0] ascii);
      return {ext, rel, code, ascii};
   endfunction

endpackage

// File: rtl/ps2_scan_ascii.sv
// Combinational Set-2 scan code to ASCII lookup for the primary key set.
// Unmapped codes give 0x00; letters are lowercase unless upper is set.
module ps2_scan_ascii (
   input  logic [7:0] code,
   input  logic       upper,
   output logic [7:0] ascii
);

   logic       letter;
   logic [4:0] letter_idx;

   // Letters resolve to an alphabet index so case is applied in one place.
   always_comb begin
      ascii      = 8'h00;
      letter     = 1'b0;
      letter_idx = 5'd0;
      case (code)
         8'h1C: begin letter = 1'b1; letter_idx = 5'd0;  end
         8'h32: begin letter = 1'b1; letter_idx = 5'd1;  end
         8'h21: begin letter = 1'b1; letter_idx = 5'd2;  end
         8'h23: begin letter = 1'b1; letter_idx = 5'd3;  end
         8'h24: begin letter = 1'b1; letter_idx = 5'd4;  end
         8'h2B: begin letter = 1'b1; letter_idx = 5'd5;  end
         8'h34: begin letter = 1'b1; letter_idx = 5'd6;  end
         8'h33: begin letter = 1'b1; letter_idx = 5'd7;  end
         8'h43: begin letter = 1'b1; letter_idx = 5'd8;  end
         8'h3B: begin letter = 1'b1; letter_idx = 5'd9;  end
         8'h42: begin letter = 1'b1; letter_idx = 5'd10; end
         8'h4B: begin letter = 1'b1; letter_idx = 5'd11; end
         8'h3A: begin letter = 1'b1; letter_idx = 5'd12; end
         8'h31: begin letter = 1'b1; letter_idx = 5'd13; end
         8'h44: begin letter = 1'b1; letter_idx = 5'd14; end
         8'h4D: begin letter = 1'b1; letter_idx = 5'd15; end
         8'h15: begin letter = 1'b1; letter_idx = 5'd16; end
         8'h2D: begin letter = 1'b1; letter_idx = 5'd17; end
         8'h1B: begin letter = 1'b1; letter_idx = 5'd18; end
         8'h2C: begin letter = 1'b1; letter_idx = 5'd19; end
         8'h3C: begin letter = 1'b1; letter_idx = 5'd20; end
         8'h2A: begin letter = 1'b1; letter_idx = 5'd21; end
         8'h1D: begin letter = 1'b1; letter_idx = 5'd22; end
         8'h22: begin letter = 1'b1; letter_idx = 5'd23; end
         8'h35: begin letter = 1'b1; letter_idx = 5'd24; end
         8'h1A: begin letter = 1'b1; letter_idx = 5'd25; end
         8'h45: ascii = 8'h30;
         8'h16: ascii = 8'h31;
         8'h1E: ascii = 8'h32;
         8'h26: ascii = 8'h33;
         8'h25: ascii = 8'h34;
         8'h2E: ascii = 8'h35;
         8'h36: ascii = 8'h36;
         8'h3D: ascii = 8'h37;
         8'h3E: ascii = 8'h38;
         8'h46: ascii = 8'h39;
         8'h29: ascii = 8'h20;
         8'h5A: ascii = 8'h0D;
         8'h66: ascii = 8'h08;
         8'h76: ascii = 8'h1B;
         default: ascii = 8'h00;
      endcase
      if (letter) begin
         ascii = (upper ? 8'h41 : 8'h61) + {3'b000, letter_idx};
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns the PS/2 scan-code byte stream into make/break key events, tracks
// shift and caps-lock, counts presses and queues events in a show-ahead FIFO.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             code_valid,
   input  logic [7:0]       code,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [7:0]       ev_code,
   output logic [7:0]       ev_ascii,
   output logic             ev_ext,
   output logic             ev_release,
   output logic             key_down,
   output logic             shift_held,
   output logic             caps_lock,
   output logic [CNT_W-1:0] press_count,
   output logic             overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   ps2_state_e       state_q, state_d;
   logic [7:0]       held_code_q, held_code_d;
   logic             held_ext_q, held_ext_d;
   logic             key_down_q, key_down_d;
   logic             shift_l_q, shift_l_d;
   logic             shift_r_q, shift_r_d;
   logic             caps_q, caps_d;
   logic [CNT_W-1:0] press_q, press_d;
   logic             overflow_q, overflow_d;
   logic [EV_W-1:0]  mem_q [FIFO_DEPTH];
   logic [EV_W-1:0]  mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;

   logic             emit;
   logic             new_ext;
   logic             new_rel;
   logic             upper;
   logic [7:0]       lookup_ascii;
   logic [7:0]       new_ascii;
   logic             same_key;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic [EV_W-1:0]  head;

   assign upper = (shift_l_q | shift_r_q) ^ caps_q;

   ps2_scan_ascii u_scan_ascii (
      .code  (code),
      .upper (upper),
      .ascii (lookup_ascii)
   );

   assign new_ascii = new_ext ? 8'h00 : lookup_ascii;
   assign same_key  = key_down_q && (held_ext_q == new_ext) && (held_code_q == code);

   // Prefix sequencer: collects E0/F0 prefixes and decides when a byte is a key event.
   always_comb begin
      state_d = state_q;
      emit    = 1'b0;
      new_ext = 1'b0;
      new_rel = 1'b0;
      if (code_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (code == PS2_EXT) begin
                  state_d = ST_EXT;
               end else if (code == PS2_BRK) begin
                  state_d = ST_BRK;
               end else if (code == PS2_ACK || code == PS2_BAT || code == PS2_PAUSE) begin
                  state_d = ST_IDLE;
               end else begin
                  emit = 1'b1;
               end
            end
            ST_EXT: begin
               if (code == PS2_BRK) begin
                  state_d = ST_EXT_BRK;
               end else if (code == PS2_EXT) begin
                  state_d = ST_EXT;
               end else begin
                  emit    = 1'b1;
                  new_ext = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_BRK: begin
               emit    = 1'b1;
               new_rel = 1'b1;
               state_d = ST_IDLE;
            end
            ST_EXT_BRK: begin
               emit    = 1'b1;
               new_ext = 1'b1;
               new_rel = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Held-key, modifier and press-count bookkeeping for each decoded event.
   always_comb begin
      held_code_d = held_code_q;
      held_ext_d  = held_ext_q;
      key_down_d  = key_down_q;
      shift_l_d   = shift_l_q;
      shift_r_d   = shift_r_q;
      caps_d      = caps_q;
      press_d     = press_q;
      if (emit && !new_rel) begin
         held_code_d = code;
         held_ext_d  = new_ext;
         key_down_d  = 1'b1;
         if (!same_key) begin
            press_d = press_q + CNT_W'(1);
         end
         if (!new_ext) begin
            if (code == PS2_LSHIFT) shift_l_d = 1'b1;
            if (code == PS2_RSHIFT) shift_r_d = 1'b1;
            if (code == PS2_CAPS && !same_key) caps_d = ~caps_q;
         end
      end else if (emit && new_rel) begin
         if (same_key) begin
            key_down_d = 1'b0;
         end
         if (!new_ext) begin
            if (code == PS2_LSHIFT) shift_l_d = 1'b0;
            if (code == PS2_RSHIFT) shift_r_d = 1'b0;
         end
      end
   end

   assign fifo_full  = (occ_q == OCC_W'(FIFO_DEPTH));
   assign fifo_empty = (occ_q == '0);
   assign pop        = ev_ready && !fifo_empty;
   assign push       = emit && (!fifo_full || pop);

   // Event FIFO: a pop in the same cycle frees room for a push into a full queue.
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      overflow_d = overflow_q;
      if (push) begin
         mem_d[wr_ptr_q] = pack_event(new_ext, new_rel, code, new_ascii);
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (pop && !push) begin
         occ_d = occ_q - OCC_W'(1);
      end
      if (emit && fifo_full && !pop) begin
         overflow_d = 1'b1;
      end
   end

   // Control and status registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         held_code_q <= 8'h00;
         held_ext_q  <= 1'b0;
         key_down_q  <= 1'b0;
         shift_l_q   <= 1'b0;
         shift_r_q   <= 1'b0;
         caps_q      <= 1'b0;
         press_q     <= '0;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
      end else begin
         state_q     <= state_d;
         held_code_q <= held_code_d;
         held_ext_q  <= held_ext_d;
         key_down_q  <= key_down_d;
         shift_l_q   <= shift_l_d;
         shift_r_q   <= shift_r_d;
         caps_q      <= caps_d;
         press_q     <= press_d;
         overflow_q  <= overflow_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
      end
   end

   // FIFO storage needs no reset; entries are only read while occupied.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head        = mem_q[rd_ptr_q];
   assign ev_valid    = !fifo_empty;
   assign ev_ext      = head[EV_EXT_BIT];
   assign ev_release  = head[EV_REL_BIT];
   assign ev_code     = head[EV_CODE_LSB +: 8];
   assign ev_ascii    = head[EV_ASCII_LSB +: 8];
   assign key_down    = key_down_q;
   assign shift_held  = shift_l_q | shift_r_q;
   assign caps_lock   = caps_q;
   assign press_count = press_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed sequences pinned with literal values,
// then random byte streams checked every cycle against a behavioural model.
module tb_ps2_key_decoder;

   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
      8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   localparam logic [7:0] DIGITS [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
      8'h3D, 8'h3E, 8'h46};
   localparam logic [7:0] MISC [7] = '{8'h29, 8'h5A, 8'h66, 8'h76, 8'h12, 8'h59, 8'h58};

   logic             clk = 1'b0;
   logic             resetn;
   logic             code_valid;
   logic [7:0]       code;
   logic             ev_valid;
   logic             ev_ready;
   logic [7:0]       ev_code;
   logic [7:0]       ev_ascii;
   logic             ev_ext;
   logic             ev_release;
   logic             key_down;
   logic             shift_held;
   logic             caps_lock;
   logic [CNT_W-1:0] press_count;
   logic             overflow;

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural model state
   bit          m_init = 1'b0;
   bit          m_ext_pend, m_brk_pend;
   logic [17:0] m_q [$];
   bit          m_down;
   logic [8:0]  m_held;
   bit          m_shl, m_shr, m_caps, m_ovf;
   int          m_presses;

   ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .code_valid  (code_valid),
      .code        (code),
      .ev_valid    (ev_valid),
      .ev_ready    (ev_ready),
      .ev_code     (ev_code),
      .ev_ascii    (ev_ascii),
      .ev_ext      (ev_ext),
      .ev_release  (ev_release),
      .key_down    (key_down),
      .shift_held  (shift_held),
      .caps_lock   (caps_lock),
      .press_count (press_count),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_ascii(input logic [7:0] c, input bit up);
      for (int i = 0; i < 26; i++)
         if (LETTERS[i] == c) return (up ? 8'h41 : 8'h61) + 8'(i);
      for (int i = 0; i < 10; i++)
         if (DIGITS[i] == c) return 8'h30 + 8'(i);
      case (c)
         8'h29: return 8'h20;
         8'h5A: return 8'h0D;
         8'h66: return 8'h08;
         8'h76: return 8'h1B;
         default: return 8'h00;
      endcase
   endfunction

   // Reference model: consumes the same inputs at each rising edge.
   always @(posedge clk) begin
      bit         ev, ext, rel, up, rpt;
      logic [7:0] asc;
      if (!resetn) begin
         m_init = 1'b1; m_ext_pend = 0; m_brk_pend = 0; m_q.delete();
         m_down = 0; m_held = '0; m_shl = 0; m_shr = 0; m_caps = 0; m_ovf = 0; m_presses = 0;
      end else if (m_init) begin
         ev = 0; ext = 0; rel = 0;
         if (code_valid) begin
            if (m_brk_pend) begin
               ev = 1; rel = 1; ext = m_ext_pend; m_brk_pend = 0; m_ext_pend = 0;
            end else if (code == 8'hF0) m_brk_pend = 1;
            else if (code == 8'hE0) m_ext_pend = 1;
            else if (!m_ext_pend && (code == 8'hFA || code == 8'hAA || code == 8'hE1)) ev = 0;
            else begin
               ev = 1; ext = m_ext_pend; m_ext_pend = 0;
            end
         end
         if (ev_ready && m_q.size() > 0) void'(m_q.pop_front());
         if (ev) begin
            up  = (m_shl || m_shr) ^ m_caps;
            asc = ext ? 8'h00 : model_ascii(code, up);
            rpt = m_down && (m_held == {ext, code});
            if (!rel) begin
               if (!rpt) m_presses++;
               m_held = {ext, code};
               m_down = 1;
               if (!ext && code == 8'h12) m_shl = 1;
               if (!ext && code == 8'h59) m_shr = 1;
               if (!ext && code == 8'h58 && !rpt) m_caps = !m_caps;
            end else begin
               if (rpt) m_down = 0;
               if (!ext && code == 8'h12) m_shl = 0;
               if (!ext && code == 8'h59) m_shr = 0;
            end
            if (m_q.size() < DEPTH) m_q.push_back({ext, rel, code, asc});
            else m_ovf = 1;
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (m_init) begin
         check_output("ev_valid", ev_valid, m_q.size() != 0);
         if (m_q.size() != 0) begin
            check_output("ev_ext", ev_ext, m_q[0][17]);
            check_output("ev_release", ev_release, m_q[0][16]);
            check_output("ev_code", ev_code, m_q[0][15:8]);
            check_output("ev_ascii", ev_ascii, m_q[0][7:0]);
         end
         check_output("key_down", key_down, m_down);
         check_output("shift_held", shift_held, m_shl || m_shr);
         check_output("caps_lock", caps_lock, m_caps);
         check_output("press_count", press_count, m_presses % 256);
         check_output("overflow", overflow, m_ovf);
      end
   end

   task automatic apply_stimulus(input logic [7:0] b);
      @(negedge clk);
      code_valid = 1'b1;
      code       = b;
      @(negedge clk);
      code_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn     = 1'b0;
      code_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   function automatic logic [7:0] pick_byte();
      int r;
      r = $urandom_range(0, 11);
      case (r)
         0: return 8'hE0;
         1: return 8'hF0;
         2: return (($urandom % 3) == 0) ? 8'hFA : ((($urandom % 2) == 0) ? 8'hAA : 8'hE1);
         3: return 8'($urandom);
         4, 5: return MISC[$urandom_range(0, 6)];
         6: return DIGITS[$urandom_range(0, 9)];
         default: return LETTERS[$urandom_range(0, 3)];
      endcase
   endfunction

   initial begin
      resetn = 1'b0; code_valid = 1'b0; code = 8'h00; ev_ready = 1'b1;
      do_reset();
      check_output("reset ev_valid", ev_valid, 0);
      check_output("reset press_count", press_count, 0);
      check_output("reset caps_lock", caps_lock, 0);

      // 1: make / break of 'a'
      apply_stimulus(8'h1C);
      check_output("t1 make code", ev_code, 8'h1C);
      check_output("t1 make ascii", ev_ascii, 8'h61);
      check_output("t1 make rel", ev_release, 0);
      check_output("t1 key_down", key_down, 1);
      check_output("t1 press_count", press_count, 1);
      apply_stimulus(8'hF0);
      check_output("t1 F0 no event", ev_valid, 0);
      apply_stimulus(8'h1C);
      check_output("t1 break rel", ev_release, 1);
      check_output("t1 break ascii", ev_ascii, 8'h61);
      check_output("t1 key_up", key_down, 0);
      check_output("t1 count kept", press_count, 1);

      // 2: shift and caps
      do_reset();
      apply_stimulus(8'h12);
      check_output("t2 shift_held", shift_held, 1);
      apply_stimulus(8'h1C);
      check_output("t2 shifted A", ev_ascii, 8'h41);
      check_output("t2 press_count", press_count, 2);
      apply_stimulus(8'hF0); apply_stimulus(8'h1C);
      apply_stimulus(8'hF0); apply_stimulus(8'h12);
      check_output("t2 shift released", shift_held, 0);
      apply_stimulus(8'h58); apply_stimulus(8'hF0); apply_stimulus(8'h58);
      check_output("t2 caps on", caps_lock, 1);
      apply_stimulus(8'h1C);
      check_output("t2 caps A", ev_ascii, 8'h41);
      apply_stimulus(8'h12); apply_stimulus(8'h1C);
      check_output("t2 shift xor caps", ev_ascii, 8'h61);

      // 3: typematic repeats
      do_reset();
      repeat (3) apply_stimulus(8'h1C);
      check_output("t3 repeat count", press_count, 1);
      repeat (3) apply_stimulus(8'h58);
      check_output("t3 caps once", caps_lock, 1);
      check_output("t3 count after caps", press_count, 2);

      // 4: extended keys and reset mid-sequence
      do_reset();
      apply_stimulus(8'hE0); apply_stimulus(8'h75);
      check_output("t4 ext make ext", ev_ext, 1);
      check_output("t4 ext make code", ev_code, 8'h75);
      check_output("t4 ext make ascii", ev_ascii, 8'h00);
      apply_stimulus(8'hE0); apply_stimulus(8'hF0); apply_stimulus(8'h75);
      check_output("t4 ext break ext", ev_ext, 1);
      check_output("t4 ext break rel", ev_release, 1);
      apply_stimulus(8'hE0); apply_stimulus(8'hF0);
      do_reset();
      apply_stimulus(8'h1C);
      check_output("t4 post-reset ext", ev_ext, 0);
      check_output("t4 post-reset rel", ev_release, 0);
      check_output("t4 post-reset code", ev_code, 8'h1C);

      // 5: FIFO full, push+pop when full, overflow, drain
      do_reset();
      ev_ready = 1'b0;
      apply_stimulus(8'h16); apply_stimulus(8'h1E); apply_stimulus(8'h26); apply_stimulus(8'h25);
      check_output("t5 head '1'", ev_ascii, 8'h31);
      @(negedge clk);
      ev_ready = 1'b1; code_valid = 1'b1; code = 8'h2E;
      @(negedge clk);
      ev_ready = 1'b0; code_valid = 1'b0;
      check_output("t5 push+pop no ovf", overflow, 0);
      check_output("t5 head '2'", ev_ascii, 8'h32);
      apply_stimulus(8'h36);
      check_output("t5 overflow", overflow, 1);
      for (int i = 0; i < 4; i++) begin
         check_output("t5 drain ascii", ev_ascii, 8'h32 + 8'(i));
         ev_ready = 1'b1;
         @(negedge clk);
         ev_ready = 1'b0;
      end
      check_output("t5 drained", ev_valid, 0);

      // 6: press counter wrap and ignored bytes
      do_reset();
      ev_ready = 1'b1;
      for (int i = 0; i < 256; i++) apply_stimulus((i % 2) ? 8'h32 : 8'h1C);
      check_output("t6 wrap", press_count, 0);
      apply_stimulus(8'hFA); apply_stimulus(8'hAA);
      check_output("t6 FA/AA no event", ev_valid, 0);
      check_output("t6 key still down", key_down, 1);

      // random streams with varying consumer pressure and occasional resets
      do_reset();
      for (int phase = 0; phase < 3; phase++) begin
         for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            resetn     = ($urandom % 400) != 0;
            code_valid = ($urandom % 3) != 0;
            code       = pick_byte();
            ev_ready   = (phase == 0) ? 1'b1 : (phase == 1) ? (($urandom % 4) == 0) : (($urandom % 2) == 0);
         end
      end
      @(negedge clk);
      code_valid = 1'b0; resetn = 1'b1;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Consumes the byte stream from the PS/2 receiver stage (one scan-code byte per strobe) and turns Set-2 sequences into key events.
- Handles E0 (extended) and F0 (break) prefixes.
- Tracks the shift keys and the caps-lock toggle.
- Maps the primary key set to ASCII.
- Counts distinct key presses.
- Queues events in a small show-ahead FIFO for the display/console stage downstream.

Parameters:
FIFO_DEPTH, 4, event FIFO entries (power of two, >=2)
CNT_W, 8, width of press counter

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
code_valid  in  1  one-cycle strobe: code holds a new byte
code  in  8  received scan-code byte
ev_valid  out  1  FIFO head holds an event
ev_ready  in  1  consumer pops head when ev_valid&ev_ready
ev_code  out  8  head event scan code (prefixes stripped)
ev_ascii  out  8  head event ASCII, 0x00 if unmapped
ev_ext  out  1  head event had E0 prefix
ev_release  out  1  head event is a break
key_down  out  1  a tracked key is currently held
shift_held  out  1  left (0x12) or right (0x59) shift held
caps_lock  out  1  caps-lock toggle state
press_count  out  CNT_W  number of distinct presses, wraps modulo 2^CNT_W
overflow  out  1  sticky: event dropped because FIFO full

Behaviour:
- Reset (resetn=0 at clk edge): FSM=IDLE; FIFO emptied (ev_valid=0); key_down=0; shift_held=0; caps_lock=0; press_count=0; overflow=0. Reset mid-sequence discards any pending prefix.
- ev_* payload is don't-care while ev_valid=0.
- FSM, advanced only on code_valid:
  - IDLE: E0->EXT; F0->BRK; FA/AA/E1->IDLE, no event; else emit make(code, ext=0), stay IDLE.
  - EXT: F0->EXT_BRK; E0->EXT; else emit make(code, ext=1), ->IDLE.
  - BRK: emit break(code, ext=0), ->IDLE.
  - EXT_BRK: emit break(code, ext=1), ->IDLE.
  - A byte of F0 or E0 in BRK/EXT_BRK is taken as the code (no nesting).
- Latency: event pushed at the edge where code_valid=1 is sampled. ev_valid is high the next cycle when the FIFO was empty. key_down, shift_held, caps_lock and press_count update on that same edge.
- Held tracking, single key, register held={ext,code}:
  - Make with key_down=0: held<=key, key_down<=1, press_count+1.
  - Make equal to held (typematic repeat): event still emitted, count unchanged.
  - Make of a different key while down: held<=key, count+1.
  - Break equal to held: key_down<=0.
  - Break of another key: key_down unchanged.
  - Shift and caps-lock keys participate in held tracking like any other key.
- Shift: non-ext make 0x12/0x59 sets the respective flag, break clears it; shift_held = OR of the two flags.
- Caps: non-ext make 0x58 toggles caps_lock only when not a repeat (held != {0,0x58} or key_down=0). Break has no effect.
- ASCII applies to non-ext codes only; ext events always give 0x00.
  - Letters 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A -> a..z.
  - Uppercase (0x41..0x5A) when shift_held XOR caps_lock. Shift state is sampled before applying the current byte.
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 -> '0'..'9' (shift ignored).
  - 29->0x20, 5A->0x0D, 66->0x08, 76->0x1B.
  - Everything else -> 0x00.
  - Break events carry the same mapping as the make.
- FIFO: entry {ext,release,code,ascii}, 18 bits, show-ahead.
  - Push and pop in the same cycle are both honoured. When full, a simultaneous pop frees the slot and the push is accepted.
  - Push while full without pop: event dropped, overflow<=1 (sticky until reset). Key-state updates still occur.
  - Pop while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - Occupancy counter is log2(FIFO_DEPTH)+1 bits wide.

Decomposition:
- Shared package ps2_pkg:
  - Prefix constants PS2_EXT=0xE0, PS2_BRK=0xF0, PS2_ACK=0xFA, PS2_BAT=0xAA, PS2_PAUSE=0xE1.
  - Shift/caps codes.
  - FSM state encoding (IDLE, EXT, BRK, EXT_BRK).
  - Event field widths and offsets.
- Sub-module ps2_scan_ascii: combinational lookup (code, upper) -> ascii. Reusable by the display stage.
- FIFO stays inline.

Test Plan:
1. 0x1C, ev_ready=1 -> event {ext0, rel0, 1C, 0x61}; key_down=1; press_count=1. Then F0,1C -> {rel1, 1C, 0x61}; key_down=0; press_count=1. F0 generates no event.
2. 12, 1C, F0 1C, F0 12 -> 'A' 0x41 make; shift_held=1 between the 12 and F0 12; press_count=2. Also 58, F0 58, 1C -> caps_lock=1, 0x41. Then 12, 1C -> 0x61 (shift XOR caps).
3. 1C,1C,1C (typematic) -> three make events, press_count=1. 58,58,58 -> caps_lock toggles once.
4. E0 75, E0 F0 75 -> {ext1, rel0, 75, 0x00} then {ext1, rel1, 75, 0x00}. Also E0 F0 with resetn=0 between -> FSM IDLE; next 1C gives a plain make.
5. ev_ready=0, five makes 16,1E,26,25,2E (FIFO_DEPTH=4) -> ev_valid=1, overflow=1. Pops yield '1','2','3','4', then ev_valid=0. Full FIFO with push+pop in the same cycle -> no overflow, count stays 4.
6. press_count wrap: 256 distinct alternating presses (1C, 32, ...) -> press_count returns to 0. FA/AA bytes -> no event, no state change.
